// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution frame loader.
//   - default geometry (data width, max kernel length, core memory depth)
//   - loader FSM state encoding
//   - header error codes and the header check helper
package conv_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int NUM_PE_DEF      = 16;
    localparam int BUFFER_SIZE_DEF = 64;

    typedef enum logic [2:0] {
        ST_HDR_K,
        ST_HDR_N,
        ST_KERNEL,
        ST_SAMPLES,
        ST_CHECK,
        ST_START,
        ST_WAIT_DONE,
        ST_DISCARD
    } state_t;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_K_ZERO = 3'd1;
    localparam logic [2:0] ERR_K_BIG  = 3'd2;
    localparam int ERR_N_ZERO_I = 3;
    localparam logic [2:0] ERR_N_ZERO = 3'd3;
    localparam logic [2:0] ERR_LEN    = 3'd4;

    // Integer arithmetic so 1+K+N can never wrap and falsely fit.
    function automatic logic [2:0] hdr_check(input int k, input int n,
                                             input int num_pe, input int buf_size);
        if (k == 0)                   return ERR_K_ZERO;
        else if (k > num_pe)          return ERR_K_BIG;
        else if (n == 0)              return ERR_N_ZERO;
        else if (1 + k + n > buf_size) return ERR_LEN;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/conv_edge_detect.sv
// conv_edge_detect: registered rising-edge detector.
//   clk, reset_n : clock, async active-low reset
//   level        : input level (conv_done from the core)
//   rise         : high in the cycle where level is 1 and was 0 last cycle
module conv_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level_q <= 1'b0;
        else          level_q <= level;
    end

    assign rise = level && !level_q;

endmodule

// File: rtl/conv_frame_loader.sv
// conv_frame_loader: byte-serial frame loader in front of the 1-D convolution core.
// Frame: K, N, K kernel bytes, N sample bytes (+ checksum byte when
// CONV_LOADER_CHECKSUM_EN is defined). Writes K to addr 0, kernel to 1..K,
// samples to 1+K.. ; pulses start_conv and waits for a conv_done rise.
//   clk, reset_n         : clock, async active-low reset
//   s_data/s_valid/s_ready : input byte stream
//   mem_wr_en/addr/data  : core memory write port (registered)
//   start_conv           : one-cycle start pulse
//   conv_done            : core done level (edge-detected)
//   busy                 : high in every state but HDR_K
//   frame_err            : sticky error, cleared by next header byte
//
// state        | meaning
// HDR_K        | idle, waiting for K byte
// HDR_N        | waiting for N byte, header check on accept
// KERNEL       | writing kernel taps
// SAMPLES      | writing samples
// CHECK        | waiting for checksum byte (checksum build only)
// START        | start pulse being issued
// WAIT_DONE    | core running, stream stalled
// DISCARD      | swallowing the rest of a bad frame
module conv_frame_loader
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_PE      = NUM_PE_DEF,
    parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
    parameter int ADDR_W      = $clog2(BUFFER_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_W-1:0]     mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  start_conv,
    input  logic                  conv_done,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = DATA_WIDTH + 2;

    state_t                state;
    logic [DATA_WIDTH-1:0] k_reg;
    logic [DATA_WIDTH-1:0] n_reg;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]      payload_len;
    logic [CNT_W-1:0]      discard_len;
    logic [2:0]            hdr_err;
    logic                  accept;
    logic                  done_rise;

    assign accept      = s_valid && s_ready;
    assign payload_len = CNT_W'(k_reg) + CNT_W'(s_data);
    assign hdr_err     = hdr_check(int'(k_reg), int'(s_data), NUM_PE, BUFFER_SIZE);

    conv_edge_detect u_done_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (conv_done),
        .rise    (done_rise)
    );

`ifdef CONV_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;

    // The checksum byte is only counted in the discard when the payload
    // length itself still fits in one byte.
    assign discard_len = (payload_len <= CNT_W'((1 << DATA_WIDTH) - 1)) ?
                         payload_len + CNT_W'(1) : payload_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    sum <= '0;
        else if (accept) sum <= (state == ST_HDR_K) ? s_data : sum + s_data;
    end
`else
    assign discard_len = payload_len;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_HDR_K;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            start_conv  <= 1'b0;
            frame_err   <= 1'b0;
            k_reg       <= '0;
            n_reg       <= '0;
            cnt         <= '0;
            wr_ptr      <= '0;
        end else begin
            mem_wr_en  <= 1'b0;
            start_conv <= 1'b0;
            case (state)
                ST_HDR_K: begin
                    // s_ready comes up here on the first clock after reset.
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    if (accept) begin
                        frame_err   <= 1'b0;
                        k_reg       <= s_data;
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= '0;
                        mem_wr_data <= s_data;
                        busy        <= 1'b1;
                        state       <= ST_HDR_N;
                    end
                end
                ST_HDR_N: begin
                    if (accept) begin
                        n_reg  <= s_data;
                        wr_ptr <= ADDR_W'(1);
                        if (hdr_err != ERR_NONE) begin
                            frame_err <= 1'b1;
                            if (discard_len == '0) begin
                                busy  <= 1'b0;
                                state <= ST_HDR_K;
                            end else begin
                                cnt   <= discard_len;
                                state <= ST_DISCARD;
                            end
                        end else begin
                            cnt   <= CNT_W'(k_reg);
                            state <= ST_KERNEL;
                        end
                    end
                end
                ST_KERNEL: begin
                    if (accept) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= wr_ptr;
                        mem_wr_data <= s_data;
                        wr_ptr      <= wr_ptr + ADDR_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            cnt   <= CNT_W'(n_reg);
                            state <= ST_SAMPLES;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                ST_SAMPLES: begin
                    if (accept) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= wr_ptr;
                        mem_wr_data <= s_data;
                        wr_ptr      <= wr_ptr + ADDR_W'(1);
                        if (cnt == CNT_W'(1)) begin
`ifdef CONV_LOADER_CHECKSUM_EN
                            state   <= ST_CHECK;
`else
                            s_ready <= 1'b0;
                            state   <= ST_START;
`endif
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
`ifdef CONV_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        if (s_data == sum) begin
                            s_ready <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_HDR_K;
                        end
                    end
                end
`endif
                ST_START: begin
                    start_conv <= 1'b1;
                    state      <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done_rise) begin
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_HDR_K;
                    end
                end
                ST_DISCARD: begin
                    if (accept) begin
                        if (cnt == CNT_W'(1)) begin
                            busy  <= 1'b0;
                            state <= ST_HDR_K;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_HDR_K;
                end
            endcase
        end
    end

endmodule
